// File: rtl/mips_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters for the 5-stage MIPS fetch path.
// Optional statistics counters are built when the BTB_STATS_EN macro is defined.
module mips_btb #(
    parameter int ENTRIES  = 16,
    parameter int PC_WIDTH = 32
) (
    input  logic                ClockIn,
    input  logic                Reset,
    input  logic                IF_Valid,
    input  logic [PC_WIDTH-1:0] IF_PC,
    output logic                IF_PredTaken,
    output logic [PC_WIDTH-1:0] IF_PredTarget,
    input  logic                Upd_Valid,
    input  logic [PC_WIDTH-1:0] Upd_PC,
    input  logic                Upd_IsJump,
    input  logic                Upd_Taken,
    input  logic [PC_WIDTH-1:0] Upd_Target,
    input  logic                Upd_PredTaken,
    input  logic [PC_WIDTH-1:0] Upd_PredTarget,
    output logic                Upd_Mispredict,
    input  logic                Flush
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]         Stat_Lookups,
    output logic [31:0]         Stat_Hits,
    output logic [31:0]         Stat_Mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX_W - 2;
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(3'd4);

    // Saturating 2-bit counter step; jumps are pinned to strongly taken.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken,
                                            input logic is_jump);
        logic [1:0] nxt;
        if (is_jump) begin
            nxt = 2'd3;
        end else if (taken) begin
            nxt = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        end else begin
            nxt = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
        end
        return nxt;
    endfunction

    logic [ENTRIES-1:0]  valid_r;
    logic [1:0]          ctr_r    [ENTRIES];
    logic [TAG_W-1:0]    tag_r    [ENTRIES];
    logic [PC_WIDTH-1:0] target_r [ENTRIES];
    logic                jump_r   [ENTRIES];

    logic [IDX_W-1:0]    lk_idx_s;
    logic [TAG_W-1:0]    lk_tag_s;
    logic                lk_hit_s;
    logic                lk_taken_s;
    logic [IDX_W-1:0]    upd_idx_s;
    logic [TAG_W-1:0]    upd_tag_s;
    logic                upd_hit_s;
    logic                upd_we_s;
    logic [1:0]          upd_ctr_s;

    // Fetch-side lookup: purely combinational, reads pre-update contents.
    always_comb begin
        lk_idx_s   = IF_PC[IDX_W+1:2];
        lk_tag_s   = IF_PC[PC_WIDTH-1:IDX_W+2];
        lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
        lk_taken_s = lk_hit_s && (jump_r[lk_idx_s] || ctr_r[lk_idx_s][1]);
        if (lk_taken_s) begin
            IF_PredTarget = target_r[lk_idx_s];
        end else begin
            IF_PredTarget = IF_PC + PC_STEP;
        end
        IF_PredTaken = lk_taken_s;
    end

    // Resolution side: mispredict flag and the write decision for the table.
    always_comb begin
        upd_idx_s      = Upd_PC[IDX_W+1:2];
        upd_tag_s      = Upd_PC[PC_WIDTH-1:IDX_W+2];
        upd_hit_s      = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
        Upd_Mispredict = Upd_Valid && ((Upd_Taken != Upd_PredTaken) ||
                                       (Upd_Taken && (Upd_Target != Upd_PredTarget)));
        // A miss only allocates on a taken outcome; a flush suppresses any write.
        upd_we_s       = Upd_Valid && !Flush && (upd_hit_s || Upd_Taken);
        if (upd_hit_s) begin
            upd_ctr_s = ctr_step(ctr_r[upd_idx_s], Upd_Taken, Upd_IsJump);
        end else if (Upd_IsJump) begin
            upd_ctr_s = 2'd3;
        end else begin
            upd_ctr_s = 2'd2;
        end
    end

    // Valid bits and counters: cleared asynchronously so a reset invalidates at once.
    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            valid_r <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= 2'd0;
            end
        end else if (Flush) begin
            valid_r <= '0;
        end else if (upd_we_s) begin
            valid_r[upd_idx_s] <= 1'b1;
            ctr_r[upd_idx_s]   <= upd_ctr_s;
        end
    end

    // Payload fields need no reset; they are only observed behind a valid bit.
    always_ff @(posedge ClockIn) begin
        if (upd_we_s) begin
            tag_r[upd_idx_s]  <= upd_tag_s;
            jump_r[upd_idx_s] <= Upd_IsJump;
            if (Upd_Taken) begin
                target_r[upd_idx_s] <= Upd_Target;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups_r;
    logic [31:0] stat_hits_r;
    logic [31:0] stat_mispredicts_r;

    // Saturating performance counters; untouched by Flush.
    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            stat_lookups_r     <= 32'd0;
            stat_hits_r        <= 32'd0;
            stat_mispredicts_r <= 32'd0;
        end else begin
            if (IF_Valid && (stat_lookups_r != 32'hFFFF_FFFF)) begin
                stat_lookups_r <= stat_lookups_r + 32'd1;
            end
            if (IF_Valid && lk_hit_s && (stat_hits_r != 32'hFFFF_FFFF)) begin
                stat_hits_r <= stat_hits_r + 32'd1;
            end
            if (Upd_Mispredict && (stat_mispredicts_r != 32'hFFFF_FFFF)) begin
                stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
            end
        end
    end

    assign Stat_Lookups     = stat_lookups_r;
    assign Stat_Hits        = stat_hits_r;
    assign Stat_Mispredicts = stat_mispredicts_r;

    logic unused_s;
    assign unused_s = ^{IF_PC[1:0], Upd_PC[1:0]};
`else
    logic unused_s;
    assign unused_s = ^{IF_Valid, IF_PC[1:0], Upd_PC[1:0]};
`endif

endmodule

// File: tb/tb_mips_btb.sv
// Self-checking bench for mips_btb: directed scenarios plus random traffic against a line-address model.
module tb_mips_btb;

    localparam int ENTRIES = 16;

    logic        ClockIn = 1'b0;
    logic        Reset = 1'b0;
    logic        IF_Valid = 1'b0;
    logic [31:0] IF_PC = 32'h0;
    logic        IF_PredTaken;
    logic [31:0] IF_PredTarget;
    logic        Upd_Valid = 1'b0;
    logic [31:0] Upd_PC = 32'h0;
    logic        Upd_IsJump = 1'b0;
    logic        Upd_Taken = 1'b0;
    logic [31:0] Upd_Target = 32'h0;
    logic        Upd_PredTaken = 1'b0;
    logic [31:0] Upd_PredTarget = 32'h0;
    logic        Upd_Mispredict;
    logic        Flush = 1'b0;
`ifdef BTB_STATS_EN
    logic [31:0] Stat_Lookups, Stat_Hits, Stat_Mispredicts;
`endif

    mips_btb #(.ENTRIES(ENTRIES), .PC_WIDTH(32)) dut (
        .ClockIn(ClockIn), .Reset(Reset), .IF_Valid(IF_Valid), .IF_PC(IF_PC),
        .IF_PredTaken(IF_PredTaken), .IF_PredTarget(IF_PredTarget),
        .Upd_Valid(Upd_Valid), .Upd_PC(Upd_PC), .Upd_IsJump(Upd_IsJump),
        .Upd_Taken(Upd_Taken), .Upd_Target(Upd_Target),
        .Upd_PredTaken(Upd_PredTaken), .Upd_PredTarget(Upd_PredTarget),
        .Upd_Mispredict(Upd_Mispredict), .Flush(Flush)
`ifdef BTB_STATS_EN
        , .Stat_Lookups(Stat_Lookups), .Stat_Hits(Stat_Hits), .Stat_Mispredicts(Stat_Mispredicts)
`endif
    );

    always #5 ClockIn = ~ClockIn;

    int n_assert = 0;
    int n_fail = 0;

    // Reference model: each slot remembers the full word address (PC>>2) it holds.
    bit          m_valid  [ENTRIES];
    logic [31:0] m_line   [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    bit          m_jump   [ENTRIES];
    logic [31:0] m_lookups, m_hits, m_mis;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_line[slot(pc)] == (pc >> 2));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_jump[slot(pc)] || m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        logic [31:0] r;
        r = m_taken(pc) ? m_target[slot(pc)] : pc + 32'd4;
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i] = 0;
        end
        m_lookups = 32'd0;
        m_hits = 32'd0;
        m_mis = 32'd0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of traffic: check combinational outputs, clock, then advance the model.
    task automatic cycle(input bit v, input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                         input bit ij, input bit ut, input logic [31:0] utg,
                         input bit upt, input logic [31:0] uptg, input bit fl);
        bit exp_mis;
        int s;
        IF_Valid = v; IF_PC = pc; Upd_Valid = uv; Upd_PC = upc; Upd_IsJump = ij;
        Upd_Taken = ut; Upd_Target = utg; Upd_PredTaken = upt; Upd_PredTarget = uptg; Flush = fl;
        #1;
        exp_mis = uv && ((ut != upt) || (ut && (utg != uptg)));
        check("pred_taken", {31'd0, IF_PredTaken}, {31'd0, m_taken(pc)});
        check("pred_target", IF_PredTarget, m_next(pc));
        check("mispredict", {31'd0, Upd_Mispredict}, {31'd0, exp_mis});
`ifdef BTB_STATS_EN
        check("stat_lookups", Stat_Lookups, m_lookups);
        check("stat_hits", Stat_Hits, m_hits);
        check("stat_mispredicts", Stat_Mispredicts, m_mis);
`endif
        @(posedge ClockIn);
        if (v) m_lookups = sat_inc(m_lookups);
        if (v && m_hit(pc)) m_hits = sat_inc(m_hits);
        if (exp_mis) m_mis = sat_inc(m_mis);
        s = slot(upc);
        if (fl) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        end else if (uv && m_hit(upc)) begin
            if (ij) m_ctr[s] = 3;
            else if (ut) m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
            else m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
            if (ut) m_target[s] = utg;
            m_jump[s] = ij;
        end else if (uv && ut) begin
            m_valid[s] = 1'b1; m_line[s] = upc >> 2; m_target[s] = utg;
            m_ctr[s] = ij ? 3 : 2; m_jump[s] = ij;
        end
        @(negedge ClockIn);
    endtask

    // Resolve a branch whose carried prediction is the model's own prediction.
    task automatic upd(input logic [31:0] upc, input bit ij, input bit ut, input logic [31:0] utg);
        cycle(1'b0, upc, 1'b1, upc, ij, ut, utg, m_taken(upc), m_next(upc), 1'b0);
    endtask

    // Idle lookup with fixed expected values taken from the scenario itself.
    task automatic peek(input string tag, input logic [31:0] pc, input bit exp_t,
                        input logic [31:0] exp_pc);
        IF_Valid = 1'b0; IF_PC = pc; Upd_Valid = 1'b0; Flush = 1'b0;
        #1;
        check({tag, "_taken"}, {31'd0, IF_PredTaken}, {31'd0, exp_t});
        check({tag, "_target"}, IF_PredTarget, exp_pc);
        @(negedge ClockIn);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        if ($urandom_range(0, 9) == 0) p = 32'hFFFF_FFFC;
        else p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        return p;
    endfunction

    initial begin
        logic [31:0] rpc, rupc, rtg;
        bit rij, rut;
        model_reset();
        #1;
        IF_PC = 32'h40;
        #1;
        check("reset_taken", {31'd0, IF_PredTaken}, 32'd0);
        check("reset_target", IF_PredTarget, 32'h44);
        @(negedge ClockIn);
        @(negedge ClockIn);
        Reset = 1'b1;

        // Allocation on a taken miss, then counter walk 2->1->0->1->2.
        cycle(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        peek("alloc", 32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 1'b0, 32'h0);
        peek("nt1", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 1'b0, 32'h0);
        peek("nt2", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 1'b1, 32'h100);
        peek("t1", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 1'b1, 32'h100);
        peek("t2", 32'h40, 1'b1, 32'h100);

        // Jump entry stays strongly taken; an aliased PC misses.
        upd(32'h80, 1'b1, 1'b1, 32'h200);
        peek("jump", 32'h80, 1'b1, 32'h200);
        upd(32'h80, 1'b1, 1'b0, 32'h0);
        upd(32'h80, 1'b1, 1'b0, 32'h0);
        peek("jump_held", 32'h80, 1'b1, 32'h200);
        peek("alias", 32'h80 + 4 * ENTRIES, 1'b0, 32'h84 + 4 * ENTRIES);

        // Same-cycle lookup and allocation of one index returns pre-update data.
        cycle(1'b1, 32'hC4, 1'b1, 32'hC4, 1'b0, 1'b1, 32'h340, 1'b0, 32'h0, 1'b0);
        peek("no_bypass_after", 32'hC4, 1'b1, 32'h340);

        // Flush wins over a simultaneous update.
        cycle(1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
        peek("flush_a", 32'h40, 1'b0, 32'h44);
        peek("flush_b", 32'h80, 1'b0, 32'h84);
        peek("flush_upd", 32'h300, 1'b0, 32'h304);
        peek("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Statistics scenario: 10 lookups, 3 hits, 2 mispredicts after a fresh reset.
        Reset = 1'b0;
        @(negedge ClockIn);
        model_reset();
        Reset = 1'b1;
        cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, (i < 3) ? 32'h40 : 32'h500, (i == 4 || i == 7), 32'h600, 1'b0,
                  1'b0, 32'h0, 1'b1, 32'h700, 1'b0);
        end
`ifdef BTB_STATS_EN
        check("stats_lookups10", Stat_Lookups, 32'd10);
        check("stats_hits3", Stat_Hits, 32'd3);
        check("stats_mis2", Stat_Mispredicts, 32'd2);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("stats_flush_hold", Stat_Lookups, 32'd10);
`endif

        // Asynchronous reset between clock edges invalidates immediately.
        upd(32'h40, 1'b0, 1'b1, 32'h120);
        IF_Valid = 1'b0; IF_PC = 32'h40; Upd_Valid = 1'b0; Flush = 1'b0;
        #1;
        check("pre_async_taken", {31'd0, IF_PredTaken}, 32'd1);
        Reset = 1'b0;
        #1;
        model_reset();
        check("async_rst_taken", {31'd0, IF_PredTaken}, 32'd0);
        check("async_rst_target", IF_PredTarget, 32'h44);
`ifdef BTB_STATS_EN
        check("async_rst_stats", Stat_Lookups, 32'd0);
`endif
        @(negedge ClockIn);
        Reset = 1'b1;
        peek("post_rst", 32'h40, 1'b0, 32'h44);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rpc = rand_pc();
            rupc = rand_pc();
            rij = ($urandom_range(0, 5) == 0);
            rut = rij ? 1'b1 : 1'($urandom_range(0, 1));
            rtg = {24'd0, 8'($urandom_range(0, 3) << 4)} | 32'h1000;
            if ($urandom_range(0, 1) == 1)
                cycle(1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 3) != 0), rupc, rij, rut,
                      rtg, m_taken(rupc), m_next(rupc), ($urandom_range(0, 40) == 0));
            else
                cycle(1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 3) != 0), rupc, rij, rut,
                      rtg, 1'($urandom_range(0, 1)), rtg, ($urandom_range(0, 40) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_btb.md
# mips_btb

Direct-mapped branch target buffer for the 5-stage MIPS pipeline, generalising the fixed ID-stage jump mux into a parametrised predictor. Looks up the IF-stage PC combinationally and returns a predicted next PC (target or PC+4). It learns from resolved branches and jumps reported by the ID/EX resolution point, using 2-bit saturating counters. Optional statistics counters are provided for performance bring-up.

## Interface
- `ENTRIES`, 16: table depth; power of two, ≥2; `IDX_W = log2(ENTRIES)`.
- `PC_WIDTH`, 32: PC and target width.
- `ClockIn`  in  1  pipeline clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset (0 = reset).
- `IF_Valid`  in  1  IF-stage lookup is real (not stalled/bubble); gates statistics only.
- `IF_PC`  in  PC_WIDTH  fetch PC.
- `IF_PredTaken`  out  1  prediction: redirect fetch.
- `IF_PredTarget`  out  PC_WIDTH  predicted next PC.
- `Upd_Valid`  in  1  a branch or jump resolved this cycle.
- `Upd_PC`  in  PC_WIDTH  PC of the resolved instruction.
- `Upd_IsJump`  in  1  instruction is an unconditional jump (j/jal/jr).
- `Upd_Taken`  in  1  actual outcome (forced 1 by the pipeline for jumps).
- `Upd_Target`  in  PC_WIDTH  actual taken target.
- `Upd_PredTaken`  in  1  prediction made for this instruction, carried down the pipeline.
- `Upd_PredTarget`  in  PC_WIDTH  predicted target, carried down the pipeline.
- `Upd_Mispredict`  out  1  combinational mispredict flag for the flush logic.
- `Flush`  in  1  invalidate every entry.
- `Stat_Lookups`, `Stat_Hits`, `Stat_Mispredicts`  out  32 each  statistics; present only with `BTB_STATS_EN`.

## Operation
- Entry fields: `valid`, `tag[PC_WIDTH-IDX_W-2]`, `target[PC_WIDTH]`, `ctr[2]`, `jump`.
- Index is `PC[IDX_W+1:2]`; tag is `PC[PC_WIDTH-1:IDX_W+2]`. `PC[1:0]` is ignored.
- Hit: the entry at the index has `valid` set and a matching tag.
- `IF_PredTaken = hit & (jump | ctr[1])`.
- `IF_PredTarget = IF_PredTaken ? target : IF_PC+4`. The +4 wraps modulo 2^PC_WIDTH.
- `Upd_Mispredict = Upd_Valid & ((Upd_Taken != Upd_PredTaken) | (Upd_Taken & Upd_Target != Upd_PredTarget))`.
- Update when `Upd_Valid` and the `Upd_PC` entry hits:
  - `ctr` saturating-increments if taken and saturating-decrements if not taken (limits 0 and 3).
  - `target` is overwritten only when taken.
  - `jump` is overwritten with `Upd_IsJump`.
  - If `Upd_IsJump`, `ctr` is forced to 3.
- Update when `Upd_Valid` and the entry misses:
  - If taken: allocate and overwrite the way with `valid=1`, new tag and target, `ctr=2` (jump: 3), `jump=Upd_IsJump`.
  - If not taken: no allocation, and the table is unchanged.
- `Flush` clears all `valid` bits. Flush together with `Upd_Valid` in the same cycle: the flush wins and no update is written.
- Reset clears all `valid` bits, `ctr` to 0, and the statistics counters to 0. `tag` and `target` need not be reset.

## Timing
- Lookup latency is 0 cycles (combinational from `IF_PC`). An update is visible from the cycle after its edge.
- Same cycle, same index for lookup and update: the lookup returns the pre-update contents. There is no bypass.
- Reset outputs: `IF_PredTaken=0`, `IF_PredTarget=IF_PC+4`, `Upd_Mispredict` follows its inputs, statistics = 0.
- Reset asserted mid-operation: the table is invalidated immediately (asynchronously) and stays so until the first update after release.

## Configuration
- `BTB_STATS_EN` defined: the three 32-bit counters are instantiated and behave as follows.
  - `Stat_Lookups` +1 per cycle with `IF_Valid`.
  - `Stat_Hits` +1 per cycle with `IF_Valid & hit`.
  - `Stat_Mispredicts` +1 per cycle with `Upd_Mispredict`.
  - All saturate at 0xFFFFFFFF. `Flush` does not clear them.
- `BTB_STATS_EN` not defined: the `Stat_*` ports and their logic are absent. Prediction behaviour is identical in both builds.

## Test plan
- Reset (`Reset=0`), then `IF_PC=0x40` → `IF_PredTaken=0`, `IF_PredTarget=0x44`.
- Update `Upd_PC=0x40`, taken, target `0x100`, `Upd_PredTaken=0` → `Upd_Mispredict=1` that cycle. Next cycle `IF_PC=0x40` → taken, target `0x100`.
- Same entry, two not-taken updates (ctr 2→1→0) → predicts not taken after the first. A taken update (ctr 0→1) → still not taken. A second taken update → taken.
- Jump allocated at `0x80` → `0x200`, then not-taken updates are ignored in effect: still predicts taken (ctr held at 3). Aliased `IF_PC=0x80+4*ENTRIES` → miss, `IF_PredTarget=IF_PC+4`.
- `Flush` and `Upd_Valid` in the same cycle → the table is empty next cycle. `IF_PC=0xFFFFFFFC` miss → target `0x00000000`.
- With `BTB_STATS_EN`: 10 `IF_Valid` cycles with 3 hits and 2 mispredicts → `Stat_Lookups=10`, `Stat_Hits=3`, `Stat_Mispredicts=2`. Counters hold after `Flush` and are 0 after `Reset`.
